key_event_queue: RTL

KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

---
 rtl/key_event_queue.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/key_event_queue.sv
// Keypad event queue: turns scanner presses (and optional auto-repeats) into FWFT queue entries.
// Build option: define KEY_AUTOREPEAT_EN to include the hold/repeat timer and REPEAT state.
module key_event_queue #(
    parameter int DEPTH        = 4,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [4:0]               keyCode,
    input  logic                     ready,
    input  logic                     pop,
    output logic [4:0]               ev_code,
    output logic                     ev_repeat,
    output logic                     ev_valid,
    output logic [$clog2(DEPTH):0]   ev_count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);

`ifdef KEY_AUTOREPEAT_EN
    localparam int EW   = 6;
    localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1, REPEAT = 2'd2} key_state_t;
    logic [TW-1:0] timer_reg, timer_next;
`else
    localparam int EW = 5;
    typedef enum logic {IDLE = 1'b0, HELD = 1'b1} key_state_t;
`endif

    key_state_t    state_reg, state_next;
    logic [4:0]    held_reg, held_next;
    logic          push_reg, push_next;
    logic [EW-1:0] push_entry_reg, push_entry_next;

    // Key FSM; the decided push is registered so the queue never sees inputs combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            held_reg       <= '0;
            push_reg       <= 1'b0;
            push_entry_reg <= '0;
`ifdef KEY_AUTOREPEAT_EN
            timer_reg      <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            held_reg       <= held_next;
            push_reg       <= push_next;
            push_entry_reg <= push_entry_next;
`ifdef KEY_AUTOREPEAT_EN
            timer_reg      <= timer_next;
`endif
        end
    end

    always_comb begin
        state_next      = state_reg;
        held_next       = held_reg;
        push_next       = 1'b0;
        push_entry_next = '0;
`ifdef KEY_AUTOREPEAT_EN
        timer_next      = timer_reg;
`endif
        if (ready && (state_reg == IDLE || keyCode != held_reg)) begin
            push_next       = 1'b1;
            push_entry_next = EW'(keyCode);
            held_next       = keyCode;
            state_next      = HELD;
`ifdef KEY_AUTOREPEAT_EN
            timer_next      = TW'(REPEAT_DELAY - 1);
`endif
        end else if (!ready) begin
            state_next = IDLE;
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (timer_reg == '0) begin
            push_next       = 1'b1;
            push_entry_next = {1'b1, held_reg};
            timer_next      = TW'(REPEAT_RATE - 1);
            state_next      = REPEAT;
        end else begin
            timer_next = timer_reg - 1'b1;
        end
`endif
    end

    // FWFT queue: register-array storage, head read straight from the array.
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          overflow_reg;
    logic          do_pop, do_write;
    logic [EW-1:0] head;

    assign do_pop   = pop && (count_reg != '0);
    assign do_write = push_reg && ((count_reg != (AW+1)'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_reg] <= push_entry_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end else if (push_reg) begin
                overflow_reg <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_write, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head     = mem[rd_ptr_reg];
    assign ev_valid = (count_reg != '0);
    assign ev_count = count_reg;
    assign overflow = overflow_reg;
    assign ev_code  = ev_valid ? head[4:0] : 5'd0;
`ifdef KEY_AUTOREPEAT_EN
    assign ev_repeat = ev_valid & head[5];
`else
    assign ev_repeat = 1'b0;
`endif

endmodule
